// File: rtl/fp32_pkg.sv
// Shared IEEE 754 binary32 definitions for the FP arithmetic library:
// field slices, special encodings, operand classification and divider FSM states.
package fp32_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_MSB = 22;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = 24;
    localparam int BIAS     = 127;

    localparam logic [7:0]  EXP_INF = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC00000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIVIDE,
        ST_NORM
    } div_state_t;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_class_t;

    typedef struct packed {
        fp_class_t          cls;
        logic signed [9:0]  exp_eff;
        logic [23:0]        mant;
    } fp_unpacked_t;

    // Leading-zero count of a 24-bit mantissa; an all-zero input reports 24.
    function automatic logic [4:0] lzc24(input logic [23:0] m);
        lzc24 = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (m[i]) lzc24 = 5'(23 - i);
        end
    endfunction

endpackage

// File: rtl/mantissa_restoring_divider.sv
// Radix-2 restoring divider: floor(ma * 2^25 / mb), one quotient bit per clock, MSB first.
// The first quotient bit is resolved on the load edge itself, so ITERS bits take ITERS edges.
module mantissa_restoring_divider #(
    parameter int ITERS = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [23:0] ma,
    input  logic [23:0] mb,
    output logic [25:0] q,
    output logic        q_valid
);

    logic [24:0] r_rem;
    logic [23:0] r_mb;
    logic [25:0] r_q;
    logic [4:0]  r_cnt;
    logic        r_q_valid;

    logic [24:0] w_rem_cur;
    logic [23:0] w_div;
    logic        w_ge;
    logic [24:0] w_diff;
    logic [24:0] w_rem_kept;
    logic [24:0] w_rem_next;
    logic        w_step;

    assign w_rem_cur  = load ? {1'b0, ma} : r_rem;
    assign w_div      = load ? mb : r_mb;
    assign w_ge       = (w_rem_cur >= {1'b0, w_div});
    assign w_diff     = w_rem_cur - {1'b0, w_div};
    // Kept remainder is always below the divisor, so the shift never loses a set bit.
    assign w_rem_kept = w_ge ? w_diff : w_rem_cur;
    assign w_rem_next = w_rem_kept << 1;
    assign w_step     = load || (r_cnt != 5'd0);

    always_ff @(posedge clk) begin
        if (w_step) begin
            r_rem <= w_rem_next;
            r_q   <= load ? {25'd0, w_ge} : {r_q[24:0], w_ge};
            if (load) r_mb <= mb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 5'd0;
            r_q_valid <= 1'b0;
        end else if (load) begin
            r_cnt     <= 5'(ITERS - 1);
            r_q_valid <= 1'b0;
        end else if (r_cnt != 5'd0) begin
            r_cnt     <= r_cnt - 5'd1;
            r_q_valid <= (r_cnt == 5'd1);
        end
    end

    assign q       = r_q;
    assign q_valid = r_q_valid;

endmodule

// File: rtl/floating_point_div.sv
// Sequential binary32 divider with start/done handshake and fixed latency.
// Truncating (no rounding), canonical qNaN, overflow and divide-by-zero flags.
module floating_point_div
    import fp32_pkg::*;
#(
    parameter int LATENCY = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        overflow,
    output logic        div_by_zero,
    output logic        busy,
    output logic        done
);

    div_state_t         r_state;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic               r_sign;
    logic signed [9:0]  r_exp_q;
    fp_class_t          r_cls_a;
    fp_class_t          r_cls_b;
    logic [31:0]        r_result;
    logic               r_overflow;
    logic               r_dbz;
    logic               r_busy;
    logic               r_done;

    fp_unpacked_t       w_ua;
    fp_unpacked_t       w_ub;
    logic signed [9:0]  w_exp_q;
    logic               w_load;
    logic [25:0]        w_q;
    logic               w_q_valid;
    logic [33:0]        w_norm;

    function automatic fp_unpacked_t unpack(input logic [31:0] x);
        fp_unpacked_t u;
        logic [7:0]   e;
        logic [22:0]  f;
        logic [4:0]   lz;
        e = x[EXP_MSB:EXP_LSB];
        f = x[FRAC_MSB:0];
        u.cls.nan  = (e == EXP_INF) && (f != '0);
        u.cls.inf  = (e == EXP_INF) && (f == '0);
        u.cls.zero = (e == 8'd0) && (f == '0);
        lz = lzc24({1'b0, f});
        if (e == 8'd0) begin
            u.mant    = {1'b0, f} << lz;
            u.exp_eff = 10'sd1 - $signed({5'd0, lz});
        end else begin
            u.mant    = {1'b1, f};
            u.exp_eff = $signed({2'd0, e});
        end
        return u;
    endfunction

    // Returns {overflow, div_by_zero, result}; special cases override the computed value.
    function automatic logic [33:0] norm_pack(
        input logic              sign,
        input logic signed [9:0] exp_q,
        input logic [25:0]       q,
        input fp_class_t         ca,
        input fp_class_t         cb
    );
        logic signed [9:0] e;
        logic [22:0]       frac;
        logic [22:0]       den;
        logic [9:0]        sh;
        logic [31:0]       res;
        logic              ovf;
        logic              dbz;
        ovf = 1'b0;
        dbz = 1'b0;
        den = '0;
        sh  = '0;
        if (q[25]) begin
            frac = q[24:2];
            e    = exp_q;
        end else begin
            frac = q[23:1];
            e    = exp_q - 10'sd1;
        end
        if (e >= 10'sd255) begin
            res = {sign, EXP_INF, 23'd0};
            ovf = 1'b1;
        end else if (e <= 10'sd0) begin
            sh  = 10'sd1 - e;
            den = 23'({1'b1, frac} >> sh);
            res = (sh >= 10'd24) ? {sign, 31'd0} : {sign, 8'd0, den};
        end else begin
            res = {sign, e[7:0], frac};
        end
        if (ca.nan || cb.nan) begin
            res = QNAN;
            ovf = 1'b0;
        end else if ((ca.inf && cb.inf) || (ca.zero && cb.zero)) begin
            res = QNAN;
            ovf = 1'b0;
        end else if (ca.inf) begin
            res = {sign, EXP_INF, 23'd0};
            ovf = 1'b0;
        end else if (cb.inf) begin
            res = {sign, 31'd0};
            ovf = 1'b0;
        end else if (cb.zero) begin
            res = {sign, EXP_INF, 23'd0};
            ovf = 1'b0;
            dbz = 1'b1;
        end else if (ca.zero) begin
            res = {sign, 31'd0};
            ovf = 1'b0;
        end
        return {ovf, dbz, res};
    endfunction

    assign w_ua    = unpack(r_a);
    assign w_ub    = unpack(r_b);
    assign w_exp_q = w_ua.exp_eff - w_ub.exp_eff + 10'(BIAS);
    assign w_load  = (r_state == ST_LOAD);
    assign w_norm  = norm_pack(r_sign, r_exp_q, w_q, r_cls_a, r_cls_b);

    // LOAD + DIVIDE + NORM edges make up the exported latency.
    mantissa_restoring_divider #(
        .ITERS (LATENCY - 2)
    ) u_mant_div (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .ma      (w_ua.mant),
        .mb      (w_ub.mant),
        .q       (w_q),
        .q_valid (w_q_valid)
    );

    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && start) begin
            r_a <= a;
            r_b <= b;
        end
        if (r_state == ST_LOAD) begin
            r_sign  <= r_a[SIGN_BIT] ^ r_b[SIGN_BIT];
            r_exp_q <= w_exp_q;
            r_cls_a <= w_ua.cls;
            r_cls_b <= w_ub.cls;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_result   <= 32'd0;
            r_overflow <= 1'b0;
            r_dbz      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= start;
                    if (start) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_state <= ST_DIVIDE;
                end
                ST_DIVIDE: begin
                    if (w_q_valid) r_state <= ST_NORM;
                end
                ST_NORM: begin
                    // busy stays high through the done cycle and drops on the following edge.
                    r_state    <= ST_IDLE;
                    r_overflow <= w_norm[33];
                    r_dbz      <= w_norm[32];
                    r_result   <= w_norm[31:0];
                    r_done     <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign result      = r_result;
    assign overflow    = r_overflow;
    assign div_by_zero = r_dbz;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_floating_point_div.sv
// Directed bench for floating_point_div: vector table plus handshake, overlap and reset sequences.
module tb_floating_point_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        overflow;
    logic        div_by_zero;
    logic        busy;
    logic        done;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        dbz;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    floating_point_div #(.LATENCY(28)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .result      (result),
        .overflow    (overflow),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called #1 after an edge; the next rising edge is the accepting edge.
    task automatic pulse_start(input logic [31:0] ta, input logic [31:0] tb);
        a     = ta;
        b     = tb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_gaps, output int res_changes);
        logic [31:0] r0;
        bit          seen;
        r0 = result;
        lat = -1;
        busy_gaps = 0;
        res_changes = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                lat = i;
            end else begin
                if (!busy) busy_gaps++;
                if (result !== r0) res_changes++;
            end
        end
    endtask

    initial begin
        int lat;
        int gaps;
        int chg;
        int n_done;
        int first_lat;
        logic [31:0] first_res;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0};
        vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1};
        vecs[3]  = '{32'hBF800000, 32'h80000000, 32'h7F800000, 1'b0, 1'b1};
        vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0};
        vecs[5]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0};
        vecs[6]  = '{32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 1'b1, 1'b0};
        vecs[7]  = '{32'h00800000, 32'h40000000, 32'h00400000, 1'b0, 1'b0};
        vecs[8]  = '{32'h00000001, 32'h3F800000, 32'h00000001, 1'b0, 1'b0};
        vecs[9]  = '{32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 1'b0};
        vecs[10] = '{32'h40000000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0};
        vecs[11] = '{32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1'b0};
        vecs[12] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b0};
        vecs[13] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0};
        vecs[14] = '{32'h00000001, 32'h7F7FFFFF, 32'h00000000, 1'b0, 1'b0};
        vecs[15] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 32'h0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            pulse_start(vecs[i].a, vecs[i].b);
            wait_done(lat, gaps, chg);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd28);
            check($sformatf("v%0d_result", i), result, vecs[i].res);
            check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
            check($sformatf("v%0d_div_by_zero", i), 32'(div_by_zero), 32'(vecs[i].dbz));
            check($sformatf("v%0d_busy_gaps", i), 32'(gaps), 32'd0);
            check($sformatf("v%0d_early_result", i), 32'(chg), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_width", i), 32'(done), 32'd0);
            check($sformatf("v%0d_busy_after", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_result_held", i), result, vecs[i].res);
        end

        // Back-to-back: start raised in the done cycle is accepted.
        pulse_start(32'h40C00000, 32'h40000000);
        wait_done(lat, gaps, chg);
        check("b2b_first_result", result, 32'h40400000);
        check("b2b_busy_in_done", 32'(busy), 32'd1);
        pulse_start(32'h3F800000, 32'h40400000);
        check("b2b_busy_accepted", 32'(busy), 32'd1);
        wait_done(lat, gaps, chg);
        check("b2b_latency", 32'(lat), 32'd28);
        check("b2b_second_result", result, 32'h3EAAAAAA);
        @(posedge clk);
        #1;

        // Start pulsed mid-operation with other operands must be ignored.
        pulse_start(32'h40C00000, 32'h40000000);
        n_done = 0;
        first_lat = -1;
        first_res = '0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 6) begin
                a     = 32'h3F800000;
                b     = 32'h40400000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                if (first_lat < 0) begin
                    first_lat = c;
                    first_res = result;
                end
            end
        end
        start = 1'b0;
        check("ovl_done_count", 32'(n_done), 32'd1);
        check("ovl_latency", 32'(first_lat), 32'd28);
        check("ovl_result", first_res, 32'h40400000);
        check("ovl_result_held", result, 32'h40400000);

        // Asynchronous reset in the middle of DIVIDE.
        pulse_start(32'h3F800000, 32'h40400000);
        repeat (11) @(posedge clk);
        #1;
        check("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_result", result, 32'h0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_done = 0;
        repeat (35) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("mid_no_done", 32'(n_done), 32'd0);
        check("mid_idle_busy", 32'(busy), 32'd0);
        pulse_start(32'h7F7FFFFF, 32'h00800000);
        wait_done(lat, gaps, chg);
        check("post_rst_latency", 32'(lat), 32'd28);
        check("post_rst_result", result, 32'h7F800000);
        check("post_rst_overflow", 32'(overflow), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/floating_point_div.md
# floating_point_div

Sequential IEEE 754 single-precision divider, the inverse-operation companion to the combinational FP multiplier in the same arithmetic library. It uses a start/done handshake and computes `a / b` with a radix-2 restoring mantissa divider, one quotient bit per clock. Special-case and flag semantics match the multiplier: canonical qNaN, truncation with no rounding, and an overflow flag. Every operation takes the same fixed latency, so downstream scheduling is static.

## Interface
- `LATENCY`, default 28: clocks from the `start` sample edge to `done`. Fixed by the architecture, exported for integrators, not tunable.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request. Sampled only in IDLE.
- `a` input 32: dividend, IEEE 754 binary32. Captured on the accepting edge.
- `b` input 32: divisor, IEEE 754 binary32. Captured on the accepting edge.
- `result` output 32: quotient. Held until the next accepted `start`.
- `overflow` output 1: finite result exponent ≥ 255. Held with `result`.
- `div_by_zero` output 1: finite nonzero `a` divided by ±0. Held with `result`.
- `busy` output 1: high from the accepting edge until `done`.
- `done` output 1: one-cycle pulse; `result` and flags are valid in that cycle.

## Operation
- **FSM states:** IDLE → LOAD → DIVIDE → NORM → IDLE.
- **IDLE:** waits for `start`. `start` while `busy` is ignored; no queueing.
- **LOAD (1 cycle):**
  - Unpack the fields.
  - Normalise denormal inputs combinationally: a leading-zero count on the 24-bit mantissa; shift left until bit 23 is set; effective exponent = 1 − lz.
  - Compute sign = `a[31]` ^ `b[31]`.
  - Compute `exp_q` = ea − eb + 127, signed 10-bit.
  - Classify special cases.
- **DIVIDE (26 cycles):**
  - Restoring division of the 24-bit mantissa `ma`·2^25 by the 24-bit mantissa `mb`; 25-bit partial remainder; one quotient bit per cycle, MSB first.
  - Result Q is 26 bits, in [2^24, 2^26).
  - Runs even for special cases, to keep latency fixed.
- **NORM (1 cycle):**
  - If Q[25] = 1: frac = Q[24:2] and `exp_q` is used as is.
  - Otherwise: frac = Q[23:1] and `exp_q` − 1 is used.
  - exp ≥ 255: ±inf, `overflow` = 1.
  - exp ≤ 0: denormal; mantissa {1, frac} >> (1 − exp), 23 LSBs kept; a shift ≥ 24 gives ±0.
  - All discarded bits are truncated.
- **Special-case priority** (applied at NORM):
  1. Either operand NaN → 7FC00000.
  2. inf/inf or 0/0 → 7FC00000.
  3. `a` inf → {sign, FF, 0}.
  4. `b` inf → {sign, 0}.
  5. `b` zero → {sign, FF, 0}, `div_by_zero` = 1.
  6. `a` zero → {sign, 0}.
  7. Otherwise, the computed result.
- **Flags:** `overflow` is set only by case 7.

## Timing
- **Reset values:** `result` = 0, `overflow` = 0, `div_by_zero` = 0, `busy` = 0, `done` = 0, FSM = IDLE.
- **Latency:** `start` sampled at edge T; `busy` goes high after T; `done` is high in the cycle after edge T+28 (1 LOAD + 26 DIVIDE + 1 NORM); `busy` falls with `done`'s deassertion edge.
- **Output update:** `result` and the flags change only on the NORM→IDLE edge, together with `done` rising.
- **Back-to-back:** `start` asserted in the `done` cycle is accepted (the FSM is already IDLE). Throughput is one operation per 29 cycles.
- **Reset mid-operation:** immediate return to IDLE, outputs at reset values, no `done` pulse.

## Structure
- **Shared package `fp32_pkg`:** BIAS = 127, EXP_INF = 8'hFF, QNAN = 32'h7FC00000, and the field-slice constants. The multiplier is refactored to use the same package.
- **Sub-module `mantissa_restoring_divider`:**
  - Signals: `clk`, `rst`, `load`, `ma`[23:0], `mb`[23:0], `q`[25:0], `q_valid`.
  - Contains the remainder register, the quotient shift register and the iteration counter.
- **Top level:** holds the FSM, unpack/LZC, exponent arithmetic, classification and NORM packing.

## Test plan
- 40C00000 / 40000000 (6/2) → 40400000. `done` exactly 28 clocks after `start`; `busy` high throughout.
- 3F800000 / 40400000 (1/3) → 3EAAAAAA (truncated, not AB); no flags.
- 3F800000 / 00000000 → 7F800000 with `div_by_zero` = 1; BF800000 / 80000000 → 7F800000; 00000000 / 00000000 → 7FC00000 with `div_by_zero` = 0; 7FC00001 / 3F800000 → 7FC00000.
- 7F7FFFFF / 00800000 → 7F800000 with `overflow` = 1; 00800000 / 40000000 → 00400000 (denormal output); 00000001 / 3F800000 → 00000001 (denormal input).
- `start` pulsed at cycle 5 of an operation with different operands → ignored; the first result is unchanged and `done` pulses once.
- `rst` asserted at DIVIDE cycle 10 → `busy` = 0 and `result` = 0 immediately; no `done`. A new `start` after release completes normally in 28 clocks.
